wb_trace_collector: RTL and testbench

WB_TRACE_COLLECTOR -- requirements
Module: wb_trace_collector

---
 rtl/wb_trace_collector_if.sv | 25 ++
 rtl/wb_trace_collector.sv | 91 +++++++++
 tb/tb_wb_trace_collector.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_trace_collector_if.sv
// Writeback commit port and trace-record read port of the trace collector.
// The collector uses the slave view; the commit source / reader uses master.
interface wb_trace_collector_if #(
  parameter int DATA_W = 32
) ();
  logic              wb_valid;
  logic [DATA_W-1:0] wb_pc;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [4:0]        out_rd;
  logic [DATA_W-1:0] out_data;

  modport master (
    output wb_valid, wb_pc, wb_rd, wb_data, out_ready,
    input  out_valid, out_pc, out_rd, out_data
  );

  modport slave (
    input  wb_valid, wb_pc, wb_rd, wb_data, out_ready,
    output out_valid, out_pc, out_rd, out_data
  );
endinterface

// File: rtl/wb_trace_collector.sv
// Commit trace collector: counts commits, folds them into a rotating signature
// and queues register-writing commits in a DEPTH-entry FIFO for a reader.
module wb_trace_collector #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  wb_trace_collector_if.slave  bus,
  output logic [31:0]          commit_count,
  output logic [31:0]          signature,
  output logic                 overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_pc   [DEPTH];
  logic [4:0]        mem_rd   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic        out_valid_i;
  logic        full;
  logic        push_req;
  logic        pop;
  logic        push;
  logic [31:0] data32;
  logic [31:0] sig_next;

  generate
    if (DATA_W >= 32) begin : g_data_wide
      assign data32 = bus.wb_data[31:0];
    end else begin : g_data_narrow
      assign data32 = {{(32 - DATA_W){1'b0}}, bus.wb_data};
    end
  endgenerate

  assign out_valid_i = (count != '0);
  assign full        = (count == FULL_CNT);
  assign push_req    = bus.wb_valid && (bus.wb_rd != 5'd0);
  assign pop         = out_valid_i && bus.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push        = push_req && (!full || pop);
  assign sig_next    = {signature[30:0], signature[31]} ^ data32 ^ {27'b0, bus.wb_rd};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      commit_count <= '0;
      signature    <= '0;
      overflow     <= 1'b0;
    end else if (clear) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      commit_count <= '0;
      signature    <= '0;
      overflow     <= 1'b0;
    end else begin
      if (bus.wb_valid) begin
        commit_count <= commit_count + 32'd1;
        signature    <= sig_next;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_pc[wr_ptr]   <= bus.wb_pc;
      mem_rd[wr_ptr]   <= bus.wb_rd;
      mem_data[wr_ptr] <= bus.wb_data;
    end
  end

  assign bus.out_valid = out_valid_i;
  assign bus.out_pc    = out_valid_i ? mem_pc[rd_ptr]   : '0;
  assign bus.out_rd    = out_valid_i ? mem_rd[rd_ptr]   : '0;
  assign bus.out_data  = out_valid_i ? mem_data[rd_ptr] : '0;
endmodule

// File: tb/tb_wb_trace_collector.sv
// Bench for wb_trace_collector: directed and random commits checked against a
// queue-based reference model of the trace FIFO, counter and signature.
module tb_wb_trace_collector;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] commit_count;
  logic [31:0] signature;
  logic        overflow;

  wb_trace_collector_if #(.DATA_W(DATA_W)) bus ();

  wb_trace_collector #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .bus          (bus),
    .commit_count (commit_count),
    .signature    (signature),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  rec_t        q[$];
  logic [31:0] m_count = '0;
  logic [31:0] m_sig   = '0;
  logic        m_ovf   = 1'b0;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    rec_t head;
    head = (q.size() != 0) ? q[0] : '0;
    chk({where, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() != 0));
    chk({where, ".out_pc"},    64'(bus.out_pc),    64'(head.pc));
    chk({where, ".out_rd"},    64'(bus.out_rd),    64'(head.rd));
    chk({where, ".out_data"},  64'(bus.out_data),  64'(head.data));
    chk({where, ".count"},     64'(commit_count),  64'(m_count));
    chk({where, ".signature"}, 64'(signature),     64'(m_sig));
    chk({where, ".overflow"},  64'(overflow),      64'(m_ovf));
  endtask

  task automatic model_reset();
    q.delete();
    m_count = '0;
    m_sig   = '0;
    m_ovf   = 1'b0;
  endtask

  // Behaviour of one clock edge, from the queue's point of view.
  task automatic model_edge(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                            input logic [31:0] data, input logic rdy, input logic clr);
    int   occ;
    logic do_pop;
    rec_t r;
    if (clr) begin
      model_reset();
      return;
    end
    occ    = q.size();
    do_pop = (occ != 0) && rdy;
    if (v) begin
      m_count = m_count + 32'd1;
      m_sig   = {m_sig[30:0], m_sig[31]} ^ data ^ {27'b0, rd};
    end
    if (do_pop) void'(q.pop_front());
    if (v && rd != 5'd0) begin
      if (occ < DEPTH || do_pop) begin
        r.pc = pc; r.rd = rd; r.data = data;
        q.push_back(r);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                      input logic [31:0] data, input logic rdy, input logic clr);
    bus.wb_valid  = v;
    bus.wb_pc     = pc;
    bus.wb_rd     = rd;
    bus.wb_data   = data;
    bus.out_ready = rdy;
    clear         = clr;
    #1;
    check_outputs("pre");
    @(posedge clk);
    model_edge(v, pc, rd, data, rdy, clr);
    #1;
    check_outputs("post");
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("drain_empty", 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.wb_valid  = 1'b0;
    bus.wb_pc     = '0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_outputs("reset");

    @(negedge clk);
    reset = 1'b1;

    // Single commit right after reset release, latency one, known signature.
    step(1'b1, 32'h40, 5'd8, 32'h5, 1'b0, 1'b0);
    chk("first_sig", 64'(signature), 64'h0000000D);
    chk("first_rd",  64'(bus.out_rd), 64'd8);

    // rd==0 commit: counted and folded, never queued.
    step(1'b1, 32'h44, 5'd0, 32'hFFFF, 1'b0, 1'b0);
    drain();
    step(1'b1, 32'h48, 5'd0, 32'hFFFF, 1'b0, 1'b0);
    chk("rd0_no_push", 64'(bus.out_valid), 64'd0);

    // Nine commits into a stalled FIFO: the ninth is dropped.
    for (int i = 1; i <= 9; i++) step(1'b1, $urandom, 5'(i), $urandom, 1'b0, 1'b0);
    chk("ovf_after_9", 64'(overflow), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", 64'(bus.out_rd), 64'(i));
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    end
    chk("rd9_absent", 64'(bus.out_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO with simultaneous push and pop keeps eight entries, no overflow.
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 5'(i + 10), $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 5'd31, $urandom, 1'b1, 1'b0);
    chk("full_pushpop_ovf", 64'(overflow), 64'd0);
    n = 0;
    for (int i = 0; i < DEPTH + 2 && bus.out_valid; i++) begin
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("full_pushpop_occ", 64'(n), 64'(DEPTH));

    // Clear wins over a same-cycle commit.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 5'(i + 1), $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 5'd7, $urandom, 1'b1, 1'b1);
    chk("clr_valid", 64'(bus.out_valid), 64'd0);
    chk("clr_count", 64'(commit_count), 64'd0);
    chk("clr_sig",   64'(signature), 64'd0);

    // Random traffic, including pointer wrap, overflow and occasional clear.
    for (int i = 0; i < 300; i++) begin
      logic       v;
      logic [4:0] rd;
      v  = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(v, $urandom, rd, $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset between edges with five records queued.
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 5'(i + 1), $urandom, 1'b0, 1'b0);
    bus.wb_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 32'h1234, 5'd3, 32'hBEEF, 1'b0, 1'b0);
    chk("post_rst_latency", 64'(bus.out_valid), 64'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
